// File: rtl/itoa_writer.sv
// Signed binary to NUL-terminated ASCII numeral writer (base 10 or 16) on a byte write channel.
// Optional build macro ITOA_UPPER_EN selects uppercase hex letters 'A'-'F' instead of 'a'-'f'.
module itoa_writer #(
  parameter int ASZ  = 17,
  parameter int DSZ  = 32,
  parameter int DMAX = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           hex,
  input  logic [DSZ-1:0] vi,
  input  logic [ASZ-1:0] tib,
  output logic           bsy,
  output logic           done,
  output logic [7:0]     len,
  output logic           mem_we,
  output logic [ASZ-1:0] mem_ai,
  output logic [7:0]     mem_vi,
  output logic [2:0]     dbg_state
);

  // Start handshake: en is a level request sampled only in IDLE; bsy covers the whole
  // conversion, done pulses once, and en must drop before another start is accepted.

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_SIGN = 3'd2,
    S_EMIT = 3'd3,
    S_TERM = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam int SPW        = $clog2(DMAX + 1);
  localparam int DEC_DIGITS = ((DSZ - 1) * 30103) / 100000 + 1;
  localparam int HEX_DIGITS = (DSZ + 3) / 4;

  generate
    if (DMAX < DEC_DIGITS || DMAX < HEX_DIGITS) begin : g_dmax_check
      $error("itoa_writer: DMAX too small for DSZ");
    end
  endgenerate

  state_t         state;
  logic           hex_r;
  logic           neg_r;
  logic [ASZ-1:0] tib_r;
  logic [DSZ-1:0] mag;
  logic [SPW-1:0] sp;
  logic [3:0]     stk [DMAX];

  logic [DSZ-1:0] q;
  logic [3:0]     d;
  logic           last;
  logic           push;
  logic [SPW-1:0] top_idx;
  logic [3:0]     top_digit;
  logic [7:0]     len_inc;
  logic [ASZ-1:0] wr_next;

  function automatic logic [7:0] enc(input logic [3:0] v);
    logic [7:0] r;
    if (v < 4'd10) r = 8'h30 + {4'h0, v};
`ifdef ITOA_UPPER_EN
    else r = 8'h41 + {4'h0, v} - 8'd10;
`else
    else r = 8'h61 + {4'h0, v} - 8'd10;
`endif
    return r;
  endfunction

  always_comb begin
    q = '0;
    d = '0;
    if (hex_r) begin
      q = mag >> 4;
      d = mag[3:0];
    end else begin
      q = mag / DSZ'(10);
      d = 4'(mag - q * DSZ'(10));
    end
    last      = (q == '0);
    // The final digit of a positive value is written directly rather than pushed.
    push      = (state == S_DIV) && !(last && !neg_r);
    top_idx   = sp - SPW'(1);
    top_digit = stk[top_idx];
    len_inc   = len + 8'd1;
    wr_next   = tib_r + ASZ'(len_inc);
  end

  always_ff @(posedge clk) begin
    if (push) stk[sp] <= d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      bsy    <= 1'b0;
      done   <= 1'b0;
      len    <= '0;
      mem_we <= 1'b0;
      mem_ai <= '0;
      mem_vi <= '0;
      sp     <= '0;
      hex_r  <= 1'b0;
      neg_r  <= 1'b0;
      tib_r  <= '0;
      mag    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en) begin
            hex_r <= hex;
            neg_r <= vi[DSZ-1];
            tib_r <= tib;
            mag   <= vi[DSZ-1] ? (~vi + DSZ'(1)) : vi;
            sp    <= '0;
            bsy   <= 1'b1;
            len   <= '0;
            state <= S_DIV;
          end
        end
        S_DIV: begin
          mag <= q;
          if (push) sp <= sp + SPW'(1);
          if (last) begin
            mem_we <= 1'b1;
            mem_ai <= tib_r;
            if (neg_r) begin
              mem_vi <= 8'h2D;
              state  <= S_SIGN;
            end else begin
              mem_vi <= enc(d);
              state  <= S_EMIT;
            end
          end
        end
        S_SIGN: begin
          len    <= len_inc;
          mem_ai <= wr_next;
          mem_vi <= enc(top_digit);
          sp     <= top_idx;
          state  <= S_EMIT;
        end
        S_EMIT: begin
          len    <= len_inc;
          mem_ai <= wr_next;
          if (sp == '0) begin
            mem_vi <= 8'h00;
            state  <= S_TERM;
          end else begin
            mem_vi <= enc(top_digit);
            sp     <= top_idx;
          end
        end
        S_TERM: begin
          mem_we <= 1'b0;
          bsy    <= 1'b0;
          done   <= 1'b1;
          state  <= S_DONE;
        end
        S_DONE: begin
          if (!en) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_itoa_writer.sv
// Testbench for itoa_writer: vector table, reset-abort and hold-en sequences, random values vs. an arithmetic model.
module tb_itoa_writer;
  localparam int ASZ = 17;
  localparam int DSZ = 32;
  localparam int DMAX = 10;
`ifdef ITOA_UPPER_EN
  localparam int LETTER_A = 65;
`else
  localparam int LETTER_A = 97;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           en;
  logic           hex;
  logic [DSZ-1:0] vi;
  logic [ASZ-1:0] tib;
  logic           bsy;
  logic           done;
  logic [7:0]     len;
  logic           mem_we;
  logic [ASZ-1:0] mem_ai;
  logic [7:0]     mem_vi;
  logic [2:0]     dbg_state;

  itoa_writer #(.ASZ(ASZ), .DSZ(DSZ), .DMAX(DMAX)) dut (
    .clk(clk), .rst(rst), .en(en), .hex(hex), .vi(vi), .tib(tib),
    .bsy(bsy), .done(done), .len(len),
    .mem_we(mem_we), .mem_ai(mem_ai), .mem_vi(mem_vi), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // byte memory sampling on the opposite edge, plus write/cycle logging
  logic [7:0]     mem [0:(1<<ASZ)-1];
  logic [ASZ-1:0] wa_q[$];
  logic [7:0]     wd_q[$];
  logic [7:0]     exp_q[$];
  int bsy_cyc, done_cnt;
  int n_checks, n_errors;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      mem[mem_ai] = mem_vi;
      wa_q.push_back(mem_ai);
      wd_q.push_back(mem_vi);
    end
    if (bsy === 1'b1) bsy_cyc++;
    if (done === 1'b1) done_cnt++;
  end

  typedef struct {
    bit          hx;
    logic [31:0] v;
    logic [16:0] t;
    string       s;
  } vec_t;
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] fixcase(input logic [7:0] b);
`ifdef ITOA_UPPER_EN
    if (b >= 8'h61 && b <= 8'h66) return b - 8'h20;
`endif
    return b;
  endfunction

  function automatic void load_exp_str(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) exp_q.push_back(fixcase(8'(s[i])));
  endfunction

  // reference model: plain signed arithmetic on a 64-bit integer
  function automatic void load_exp_ref(input bit hx, input logic [31:0] v);
    longint sv, mag, base;
    int dg;
    sv   = longint'($signed(v));
    mag  = (sv < 0) ? -sv : sv;
    base = hx ? 16 : 10;
    exp_q.delete();
    do begin
      dg = int'(mag % base);
      exp_q.push_front(dg < 10 ? 8'(48 + dg) : 8'(LETTER_A + dg - 10));
      mag = mag / base;
    end while (mag != 0);
    if (sv < 0) exp_q.push_front(8'h2D);
  endfunction

  function automatic logic [31:0] atoi_mem(input logic [16:0] t, input bit hx);
    logic [16:0] a;
    longint acc;
    bit neg;
    int c, dv;
    a = t;
    acc = 0;
    neg = 0;
    if (mem[a] == 8'h2D) begin neg = 1; a = a + 17'd1; end
    for (int k = 0; k < 20 && mem[a] != 8'h00; k++) begin
      c  = int'(mem[a]);
      dv = (c >= 97) ? c - 87 : (c >= 65) ? c - 55 : c - 48;
      acc = acc * (hx ? 16 : 10) + dv;
      a = a + 17'd1;
    end
    return 32'(neg ? -acc : acc);
  endfunction

  // driver: one conversion, checked against exp_q
  task automatic run_conv(input bit hx, input logic [31:0] v, input logic [16:0] t,
                          input bit hold, input string tag);
    int n, s;
    bit seen;
    logic [7:0] lat_len;
    logic [16:0] a;
    n = exp_q.size();
    s = (n > 0 && exp_q[0] == 8'h2D) ? 1 : 0;
    seen = 0;
    lat_len = '0;
    @(negedge clk); #1;
    wa_q.delete(); wd_q.delete();
    bsy_cyc = 0; done_cnt = 0;
    hex = hx; vi = v; tib = t; en = 1'b1;
    @(posedge clk); #1;
    if (!hold) en = 1'b0;
    vi = $urandom; tib = 17'($urandom); hex = ~hx;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk); #1;
      if (done_cnt > 0) begin seen = 1; lat_len = len; end
    end
    chk({tag, " done_seen"}, 64'(seen), 64'd1);
    if (hold) begin
      repeat (10) @(negedge clk);
      #1 en = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    chk({tag, " len"}, 64'(lat_len), 64'(n));
    chk({tag, " bsy_cycles"}, 64'(bsy_cyc), 64'(2 * n - s + 1));
    chk({tag, " done_pulses"}, 64'(done_cnt), 64'd1);
    chk({tag, " write_count"}, 64'(wa_q.size()), 64'(n + 1));
    for (int i = 0; i < n + 1 && i < wa_q.size(); i++) begin
      a = t + 17'(i);
      chk($sformatf("%s addr[%0d]", tag, i), 64'(wa_q[i]), 64'(a));
      chk($sformatf("%s data[%0d]", tag, i), 64'(wd_q[i]), 64'(i < n ? exp_q[i] : 8'h00));
    end
    chk({tag, " bsy_idle"}, 64'(bsy), 64'd0);
  endtask

  initial begin
    logic [31:0] rv;
    logic [16:0] rt;
    bit rh;
    int sel;
    n_checks = 0; n_errors = 0;
    for (int i = 0; i < (1 << ASZ); i++) mem[i] = 8'hEE;
    rst = 1'b1; en = 1'b0; hex = 1'b0; vi = '0; tib = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset bsy", 64'(bsy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset len", 64'(len), 64'd0);
    chk("reset mem_we", 64'(mem_we), 64'd0);
    chk("reset mem_ai", 64'(mem_ai), 64'd0);
    chk("reset mem_vi", 64'(mem_vi), 64'd0);
    chk("reset state", 64'(dbg_state), 64'd0);
    rst = 1'b0;

    vecs.push_back('{1'b1, 32'hFFFFF808, 17'h00000, "-7f8"});
    vecs.push_back('{1'b0, 32'h00000000, 17'h00100, "0"});
    vecs.push_back('{1'b0, 32'h80000000, 17'h00200, "-2147483648"});
    vecs.push_back('{1'b1, 32'h00ABCDEF, 17'h1FFFE, "abcdef"});
    vecs.push_back('{1'b0, 32'd12345,    17'h00300, "12345"});
    vecs.push_back('{1'b1, 32'h00000000, 17'h00310, "0"});
    vecs.push_back('{1'b0, 32'h7FFFFFFF, 17'h00320, "2147483647"});
    vecs.push_back('{1'b1, 32'h80000000, 17'h00340, "-80000000"});
    vecs.push_back('{1'b1, 32'hFFFFFFFF, 17'h00360, "-1"});
    vecs.push_back('{1'b0, 32'd9,        17'h00370, "9"});
    vecs.push_back('{1'b0, 32'd10,       17'h00380, "10"});
    vecs.push_back('{1'b1, 32'd15,       17'h00390, "f"});
    vecs.push_back('{1'b1, 32'd16,       17'h003A0, "10"});
    vecs.push_back('{1'b0, 32'hFFFFFFF6, 17'h1FFFF, "-10"});
    for (int i = 0; i < vecs.size(); i++) begin
      load_exp_str(vecs[i].s);
      run_conv(vecs[i].hx, vecs[i].v, vecs[i].t, 1'b0, $sformatf("vec%0d", i));
    end

    // reset on the third EMIT cycle of 12345 aborts the conversion
    @(negedge clk); #1;
    wa_q.delete(); wd_q.delete();
    hex = 1'b0; vi = 32'd12345; tib = 17'h00400; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    for (int i = 0; i < 100 && wa_q.size() < 2; i++) begin
      @(negedge clk); #1;
    end
    chk("abort two_writes", 64'(wa_q.size()), 64'd2);
    @(posedge clk); #1;
    chk("abort we_before", 64'(mem_we), 64'd1);
    chk("abort len_before", 64'(len), 64'd2);
    rst = 1'b1;
    #1;
    chk("abort mem_we", 64'(mem_we), 64'd0);
    chk("abort bsy", 64'(bsy), 64'd0);
    chk("abort len", 64'(len), 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("abort no_more_writes", 64'(wa_q.size()), 64'd2);
    chk("abort mem[402]", 64'(mem[17'h00402]), 64'hEE);
    chk("abort mem[401]", 64'(mem[17'h00401]), 64'h32);
    load_exp_str("7");
    run_conv(1'b0, 32'd7, 17'h00410, 1'b0, "after_abort");

    // en held high through and after done; then round trip through a parser
    load_exp_str("-7f8");
    run_conv(1'b1, 32'hFFFFF808, 17'h00500, 1'b1, "hold_en");
    chk("round_trip", 64'(atoi_mem(17'h00500, 1'b1)), 64'hFFFFF808);

    // random values vs. reference model
    for (int it = 0; it < 40; it++) begin
      rh  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      if (sel == 0) rv = 32'($urandom_range(0, 20));
      else if (sel == 1) rv = 32'd0 - 32'($urandom_range(0, 20));
      else rv = $urandom;
      rt = 17'($urandom);
      load_exp_ref(rh, rv);
      run_conv(rh, rv, rt, 1'b0, $sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
